// File: rtl/controlador_barrido_display_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM encoding,
// the blank code and the segment glyphs {a,b,c,d,e,f,g}, active-high.
package controlador_barrido_display_pkg;

    typedef enum logic {
        ST_SCAN  = 1'b0,
        ST_BLANK = 1'b1
    } estado_t;

    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [6:0] SEG_OFF = 7'b000_0000;
    localparam logic [6:0] SEG_0   = 7'b111_1110;
    localparam logic [6:0] SEG_1   = 7'b011_0000;
    localparam logic [6:0] SEG_2   = 7'b110_1101;
    localparam logic [6:0] SEG_3   = 7'b111_1001;
    localparam logic [6:0] SEG_4   = 7'b011_0011;
    localparam logic [6:0] SEG_5   = 7'b101_1011;
    localparam logic [6:0] SEG_6   = 7'b101_1111;
    localparam logic [6:0] SEG_7   = 7'b111_0000;
    localparam logic [6:0] SEG_8   = 7'b111_1111;
    localparam logic [6:0] SEG_9   = 7'b111_1011;
    localparam logic [6:0] SEG_A   = 7'b111_0111;
    localparam logic [6:0] SEG_B   = 7'b001_1111;
    localparam logic [6:0] SEG_C   = 7'b100_1110;
    localparam logic [6:0] SEG_D   = 7'b011_1101;
    localparam logic [6:0] SEG_E   = 7'b100_1111;

endpackage

// File: rtl/controlador_barrido_display_hex_a_siete_seg.sv
// Combinational hex-to-segment encoder. Code 0xF (and anything unexpected)
// maps to all segments off so no X ever propagates to the display.
module hex_a_siete_seg
    import controlador_barrido_display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Glyph lookup for the selected digit code
    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/controlador_barrido_display.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment
// display. Each digit is lit for REFRESH_DIV clocks, followed by DEAD_CYCLES
// clocks with every anode off. New words arrive through a one-deep pending
// slot and are copied into the active word only at the frame boundary.
// Optional feature: LEADING_ZERO_BLANK_EN blanks leading zero digits (k>=1).
//
// Handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both 1; load_ready is 1 exactly when the pending slot is
// empty, and a sender seeing load_ready=0 must hold load_data and load_valid.
module controlador_barrido_display
    import controlador_barrido_display_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_valid,
    input  logic [4*N_DIGITS-1:0]       load_data,
    output logic                        load_ready,
    output logic [6:0]                  seg,
    output logic [N_DIGITS-1:0]         an,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx,
    output logic                        frame_done,
    output estado_t                     dbg_state
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int IW = $clog2(N_DIGITS);

    localparam logic [PW-1:0]       PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0]       DEAD_MAX  = DW'(DEAD_CYCLES - 1);
    localparam logic [IW-1:0]       IDX_MAX   = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE    = N_DIGITS'(1);

    estado_t                 state_q, state_d;
    logic [PW-1:0]           presc_q;
    logic [DW-1:0]           dead_q;
    logic [IW-1:0]           idx_q;
    logic [4*N_DIGITS-1:0]   active_q;
    logic [4*N_DIGITS-1:0]   pending_q;
    logic                    pending_full_q;

    logic                    scan_end;
    logic                    blank_end;
    logic                    boundary;
    logic                    accept;
    logic [3:0]              code_sel;
    logic [3:0]              code_dec;
    logic                    lead_zero;
    logic [6:0]              seg_dec;

    assign scan_end   = (state_q == ST_SCAN)  && (presc_q == PRESC_MAX);
    assign blank_end  = (state_q == ST_BLANK) && (dead_q == DEAD_MAX);
    assign boundary   = blank_end && (idx_q == IDX_MAX);
    assign load_ready = ~pending_full_q;
    assign accept     = load_valid && load_ready;
    assign frame_done = scan_end && (idx_q == IDX_MAX);
    assign digit_idx  = idx_q;
    assign dbg_state  = state_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: SCAN dwell ends on prescaler wrap, BLANK on dead count
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN:  if (scan_end)  state_d = ST_BLANK;
            ST_BLANK: if (blank_end) state_d = ST_SCAN;
            default:  state_d = ST_SCAN;
        endcase
    end

    // Prescaler, dead counter and digit index; each counter idles at 0
    // outside its own state so entry into SCAN/BLANK always starts from 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            dead_q  <= '0;
            idx_q   <= '0;
        end else begin
            if (state_q == ST_SCAN && !scan_end) begin
                presc_q <= presc_q + 1'b1;
            end else begin
                presc_q <= '0;
            end
            if (state_q == ST_BLANK && !blank_end) begin
                dead_q <= dead_q + 1'b1;
            end else begin
                dead_q <= '0;
            end
            if (blank_end) begin
                idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end
        end
    end

    // Pending slot and active word; apply needs a full slot and accept an
    // empty one, so both can never happen on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
        end else begin
            if (boundary && pending_full_q) begin
                active_q       <= pending_q;
                pending_full_q <= 1'b0;
            end
            if (accept) begin
                pending_q      <= load_data;
                pending_full_q <= 1'b1;
            end
        end
    end

    // Digit selection and optional leading-zero suppression
    always_comb begin
        code_sel = active_q[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        lead_zero = (idx_q != '0) && ((active_q >> {idx_q, 2'b00}) == '0);
`else
        lead_zero = 1'b0;
`endif
        code_dec = lead_zero ? CODE_BLANK : code_sel;
    end

    hex_a_siete_seg u_hex_a_siete_seg (
        .code (code_dec),
        .seg  (seg_dec)
    );

    // Registered display outputs: everything off during BLANK and reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_OFF;
        end else if (state_q == ST_SCAN) begin
            an  <= ~(AN_ONE << idx_q);
            seg <= seg_dec;
        end else begin
            an  <= '1;
            seg <= SEG_OFF;
        end
    end

endmodule

// File: tb/tb_controlador_barrido_display.sv
// Self-checking bench for controlador_barrido_display (N=4, REFRESH_DIV=4,
// DEAD_CYCLES=1). Honors LEADING_ZERO_BLANK_EN when defined.
module tb_controlador_barrido_display;
    import controlador_barrido_display_pkg::*;

    localparam int N      = 4;
    localparam int RD     = 4;
    localparam int DC     = 1;
    localparam int PERIOD = RD + DC;
    localparam int FRAME  = N * PERIOD;
    localparam int FD_PH  = (N - 1) * PERIOD + RD - 1;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          load_valid;
    logic [15:0]   load_data;
    logic          load_ready;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic [1:0]    digit_idx;
    logic          frame_done;
    estado_t       dbg_state;

    controlador_barrido_display #(
        .N_DIGITS    (N),
        .REFRESH_DIV (RD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .seg        (seg),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // scoreboard / model state
    int          n_total = 0;
    int          n_bad   = 0;
    int          mcnt    = 0;
    logic [15:0] m_active = '0;
    logic [15:0] exp_q[$];
    bit          last_acc = 1'b0;
    bit          model_ok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg_of(input logic [15:0] w, input int d);
        logic [15:0] upper;
        upper = w >> (4 * d);
        if (LZB && d > 0 && upper == 16'h0) return 7'b0;
        return glyph(upper[3:0]);
    endfunction

    // one clock: check ready, advance model across the edge, check outputs
    task automatic step();
        bit         acc;
        int         ph;
        int         d;
        bit         lit;
        logic [6:0] es;
        logic [3:0] ea;
        @(negedge clk);
        if (model_ok) chk("load_ready", load_ready, exp_q.size() == 0);
        acc = rst_n && load_valid && (exp_q.size() == 0);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mcnt     = 0;
            m_active = '0;
            exp_q.delete();
            acc      = 1'b0;
            es       = 7'b0;
            ea       = 4'b1111;
            model_ok = 1'b1;
        end else begin
            ph  = mcnt % FRAME;
            d   = ph / PERIOD;
            lit = (ph % PERIOD) < RD;
            ea  = lit ? ~(4'b0001 << d) : 4'b1111;
            es  = lit ? exp_seg_of(m_active, d) : 7'b0;
            if (ph == FRAME - 1 && exp_q.size() != 0) m_active = exp_q.pop_front();
            if (acc) exp_q.push_back(load_data);
            mcnt++;
        end
        last_acc = acc;
        chk("an", an, ea);
        chk("seg", seg, es);
        chk("seg_known", $isunknown(seg), 0);
        chk("digit_idx", digit_idx, (mcnt % FRAME) / PERIOD);
        chk("frame_done", frame_done, rst_n && ((mcnt % FRAME) == FD_PH));
        chk("state_scan", dbg_state == ST_SCAN, ((mcnt % FRAME) % PERIOD) < RD);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // driver: present a word and hold it until it is taken (bounded)
    task automatic send(input logic [15:0] w);
        load_valid = 1'b1;
        load_data  = w;
        last_acc   = 1'b0;
        for (int i = 0; i < 3 * FRAME && !last_acc; i++) step();
        chk("send_accept", last_acc, 1);
        load_valid = 1'b0;
    endtask

    task automatic wait_digit(input int d);
        for (int i = 0; i < 2 * FRAME && ((mcnt % FRAME) / PERIOD != d); i++) step();
        chk("wait_digit", (mcnt % FRAME) / PERIOD, d);
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'($urandom);
        run(3);
        rst_n      = 1'b1;
        load_valid = 1'b0;
        run(1);

        // scan order
        send(16'h3210);
        run(2 * FRAME + 5);

        // back-pressure: second word waits for the boundary
        send(16'h1234);
        send(16'hABCD);
        run(2 * FRAME + 5);

        // no tearing mid-frame
        wait_digit(2);
        send(16'h5555);
        run(2 * FRAME + 5);

        // blank code and decode
        send(16'hFE0A);
        run(2 * FRAME + 5);

        // reset mid-scan with pending full
        wait_digit(2);
        send(16'h9876);
        run(1);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        run(FRAME + 3);

        // leading zeros
        send(16'h0007);
        run(2 * FRAME + 5);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 16'($urandom);
            rst_n      = ($urandom_range(0, 149) != 0);
            step();
        end
        rst_n      = 1'b1;
        load_valid = 1'b0;
        run(2 * FRAME);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
